// File: rtl/jtframe_shram_arb.sv
// Round-robin arbiter sharing one synchronous single-port RAM between two CPU
// requesters. Each access is a fixed IDLE->ACC->CAP sequence; busy/dout are per side.

module jtframe_shram_arb_side #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic          grant,
  input  logic          cap,
  input  logic [DW-1:0] ram_dout,
  output logic          busy,
  output logic [DW-1:0] dout
);
  logic [AW:0]   tag_q, tag_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          match, hold, done;

  // valid only survives while the CPU keeps presenting the exact access it was granted
  assign match = ({addr, we} == tag_q);
  assign hold  = valid_q & cs & match;
  assign done  = cap & cs & match;
  assign busy  = cs & ~hold;
  assign dout  = dout_q;

  always_comb begin
    tag_d   = tag_q;
    valid_d = hold | done;
    dout_d  = dout_q;
    if (grant) tag_d = {addr, we};
    if (done && !we) dout_d = ram_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      tag_q   <= tag_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
    end
  end
endmodule

module jtframe_shram_arb #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_cs,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic [DW-1:0] a_dout,
  output logic          a_busy,
  input  logic          b_cs,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  output logic [DW-1:0] b_dout,
  output logic          b_busy,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] CAP  = 2'd2;

  // side 0 = A, side 1 = B
  logic [1:0]         cs_w, we_w, busy_w, req, grant_w, cap_w, svc;
  logic [1:0][AW-1:0] addr_w;
  logic [1:0][DW-1:0] din_w, dout_w;

  logic [1:0]    state_q, state_d;
  logic          gnt_q, gnt_d, last_q, last_d, win;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          ram_we_q, ram_we_d;

  assign cs_w   = {b_cs, a_cs};
  assign we_w   = {b_we, a_we};
  assign addr_w = {b_addr, a_addr};
  assign din_w  = {b_din, a_din};

  assign svc     = (state_q != IDLE) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign req     = busy_w & ~svc;
  assign win     = (&req) ? ~last_q : req[1];
  assign grant_w = (state_q == IDLE && |req) ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign cap_w   = (state_q == CAP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;

  for (genvar i = 0; i < 2; i++) begin : g_side
    jtframe_shram_arb_side #(.AW(AW), .DW(DW)) u_side (
      .clk      (clk),
      .rst_n    (rst_n),
      .cs       (cs_w[i]),
      .we       (we_w[i]),
      .addr     (addr_w[i]),
      .grant    (grant_w[i]),
      .cap      (cap_w[i]),
      .ram_dout (ram_dout),
      .busy     (busy_w[i]),
      .dout     (dout_w[i])
    );
  end

  assign a_busy   = busy_w[0];
  assign b_busy   = busy_w[1];
  assign a_dout   = dout_w[0];
  assign b_dout   = dout_w[1];
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_we   = ram_we_q;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = ram_we_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d    = ACC;
        gnt_d      = win;
        last_d     = win;
        ram_addr_d = addr_w[win];
        ram_din_d  = din_w[win];
        ram_we_d   = we_w[win];
      end
      ACC: begin
        ram_we_d = 1'b0;
        state_d  = CAP;
      end
      CAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
    end
  end
endmodule

// File: tb/tb_jtframe_shram_arb.sv
// Bench for jtframe_shram_arb: directed latency/arbitration scenarios plus a
// randomized two-CPU run checked against a shadow memory and wait-time bounds.

module tb_jtframe_shram_arb;
  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk, rst_n;
  logic          a_cs, a_we, b_cs, b_we;
  logic [AW-1:0] a_addr, b_addr, ram_addr;
  logic [DW-1:0] a_din, b_din, a_dout, b_dout, ram_din, ram_dout;
  logic          a_busy, b_busy, ram_we;

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  jtframe_shram_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_cs(a_cs), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout), .a_busy(a_busy),
    .b_cs(b_cs), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout), .b_busy(b_busy),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // synchronous single-port RAM, read data one cycle after address
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(negedge clk) if (rst_n && ram_we) we_cnt++;

  task automatic nxt;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs;
    a_cs = 0; a_we = 0; a_addr = '0; a_din = '0;
    b_cs = 0; b_we = 0; b_addr = '0; b_din = '0;
  endtask

  task automatic do_reset;
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    pre_en = 1; pre_addr = addr; pre_data = data;
    exp_mem[addr] = data;
    nxt();
    pre_en = 0;
  endtask

  task automatic drive(input int s, input logic cs, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] din);
    if (s == 0) begin a_cs = cs; a_we = we; a_addr = addr; a_din = din; end
    else        begin b_cs = cs; b_we = we; b_addr = addr; b_din = din; end
  endtask

  task automatic set_cs(input int s, input logic cs);
    if (s == 0) a_cs = cs; else b_cs = cs;
  endtask

  function automatic logic get_busy(input int s);
    return (s == 0) ? a_busy : b_busy;
  endfunction

  function automatic logic [DW-1:0] get_dout(input int s);
    return (s == 0) ? a_dout : b_dout;
  endfunction

  task automatic test_reset;
    rst_n = 0;
    idle_inputs();
    a_cs = 1;
    #3;
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
    checks++; if (ram_addr !== '0) begin failures++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); end
    checks++; if (ram_din !== '0) begin failures++; $display("FAIL reset_ram_din got=%h exp=0", ram_din); end
    checks++; if (a_dout !== '0 || b_dout !== '0) begin failures++; $display("FAIL reset_dout got=%h/%h exp=0/0", a_dout, b_dout); end
    checks++; if (a_busy !== 1'b1 || b_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b/%b exp=1/0", a_busy, b_busy); end
    a_cs = 0;
    nxt();
    rst_n = 1;
    nxt();
  endtask

  task automatic test_read_uncontested;
    int w0;
    logic eb;
    do_reset();
    preload(11'h123, 8'h5A);
    w0 = we_cnt;
    drive(0, 1, 0, 11'h123, 8'h00);
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      eb = (c < 3);
      checks++; if (a_busy !== eb) begin failures++; $display("FAIL rd_busy c=%0d got=%b exp=%b", c, a_busy, eb); end
      if (c == 1) begin checks++; if (ram_addr !== 11'h123) begin failures++; $display("FAIL rd_addr got=%h exp=123", ram_addr); end end
      if (c == 3) begin checks++; if (a_dout !== 8'h5A) begin failures++; $display("FAIL rd_dout got=%h exp=5a", a_dout); end end
      nxt();
    end
    checks++; if (we_cnt != w0) begin failures++; $display("FAIL rd_no_we got=%0d exp=0", we_cnt - w0); end
    a_cs = 0;
    nxt();
  endtask

  task automatic test_contested;
    logic ea, eb, ew;
    do_reset();
    preload(11'h010, 8'h77);
    drive(0, 1, 0, 11'h010, 8'h00);
    drive(1, 1, 1, 11'h020, 8'hC3);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      ea = (c < 3); eb = (c < 6); ew = (c == 4);
      checks++; if (a_busy !== ea || b_busy !== eb) begin failures++; $display("FAIL cont_busy c=%0d got=%b%b exp=%b%b", c, a_busy, b_busy, ea, eb); end
      checks++; if (ram_we !== ew) begin failures++; $display("FAIL cont_we c=%0d got=%b exp=%b", c, ram_we, ew); end
      if (c == 4) begin checks++; if (ram_addr !== 11'h020 || ram_din !== 8'hC3) begin failures++; $display("FAIL cont_wr got=%h/%h exp=020/c3", ram_addr, ram_din); end end
      if (c == 3) begin checks++; if (a_dout !== 8'h77) begin failures++; $display("FAIL cont_dout got=%h exp=77", a_dout); end end
      nxt();
    end
    exp_mem[11'h020] = 8'hC3;
    checks++; if (mem[11'h020] !== 8'hC3) begin failures++; $display("FAIL cont_mem got=%h exp=c3", mem[11'h020]); end
    idle_inputs();
    nxt();
  endtask

  // last grant goes to A via a lone access, so the next tie goes to B
  task automatic test_round_robin;
    logic ea, eb;
    drive(0, 1, 0, 11'h010, 8'h00);
    repeat (3) nxt();
    idle_inputs();
    nxt();
    drive(0, 1, 0, 11'h020, 8'h00);
    drive(1, 1, 0, 11'h010, 8'h00);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      ea = (c < 6); eb = (c < 3);
      checks++; if (a_busy !== ea || b_busy !== eb) begin failures++; $display("FAIL rr_busy c=%0d got=%b%b exp=%b%b", c, a_busy, b_busy, ea, eb); end
      if (c == 1) begin checks++; if (ram_addr !== 11'h010) begin failures++; $display("FAIL rr_first got=%h exp=010", ram_addr); end end
      if (c == 3) begin checks++; if (b_dout !== 8'h77) begin failures++; $display("FAIL rr_bdout got=%h exp=77", b_dout); end end
      if (c == 6) begin checks++; if (a_dout !== exp_mem[11'h020]) begin failures++; $display("FAIL rr_adout got=%h exp=%h", a_dout, exp_mem[11'h020]); end end
      nxt();
    end
    idle_inputs();
    nxt();
  endtask

  task automatic test_addr_change;
    logic eb;
    preload(11'h001, 8'h21);
    preload(11'h002, 8'h42);
    drive(0, 1, 0, 11'h001, 8'h00);
    repeat (3) nxt();
    @(negedge clk);
    checks++; if (a_busy !== 1'b0 || a_dout !== 8'h21) begin failures++; $display("FAIL chg_first got=%b/%h exp=0/21", a_busy, a_dout); end
    nxt();
    a_addr = 11'h002;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      eb = (c < 3);
      checks++; if (a_busy !== eb) begin failures++; $display("FAIL chg_busy c=%0d got=%b exp=%b", c, a_busy, eb); end
      if (c == 1) begin checks++; if (ram_addr !== 11'h002) begin failures++; $display("FAIL chg_addr got=%h exp=002", ram_addr); end end
      if (c == 3) begin checks++; if (a_dout !== 8'h42) begin failures++; $display("FAIL chg_dout got=%h exp=42", a_dout); end end
      nxt();
    end
    a_cs = 0;
    nxt();
  endtask

  task automatic test_cs_drop;
    int w0;
    logic eb;
    w0 = we_cnt;
    drive(0, 1, 1, 11'h040, 8'h99);
    nxt();
    a_cs = 0;
    @(negedge clk);
    checks++; if (ram_we !== 1'b1 || ram_addr !== 11'h040) begin failures++; $display("FAIL drop_acc got=%b/%h exp=1/040", ram_we, ram_addr); end
    repeat (2) nxt();
    @(negedge clk);
    checks++; if (we_cnt - w0 != 1) begin failures++; $display("FAIL drop_pulses got=%0d exp=1", we_cnt - w0); end
    checks++; if (mem[11'h040] !== 8'h99) begin failures++; $display("FAIL drop_mem got=%h exp=99", mem[11'h040]); end
    exp_mem[11'h040] = 8'h99;
    nxt();
    a_cs = 1;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      eb = (c < 3);
      checks++; if (a_busy !== eb) begin failures++; $display("FAIL drop_rearb c=%0d got=%b exp=%b", c, a_busy, eb); end
      nxt();
    end
    checks++; if (we_cnt - w0 != 2) begin failures++; $display("FAIL drop_total got=%0d exp=2", we_cnt - w0); end
    a_cs = 0;
    nxt();
  endtask

  task automatic test_reset_mid;
    logic eb;
    do_reset();
    preload(11'h0AC, 8'h11);
    preload(11'h0AB, 8'h3C);
    drive(1, 1, 0, 11'h0AC, 8'h00);
    repeat (3) nxt();
    @(negedge clk);
    checks++; if (b_dout !== 8'h11) begin failures++; $display("FAIL rst_pre got=%h exp=11", b_dout); end
    nxt();
    b_cs = 0;
    nxt();
    drive(1, 1, 0, 11'h0AB, 8'h00);
    repeat (2) nxt();
    rst_n = 0;
    #1;
    checks++; if (ram_we !== 1'b0 || ram_addr !== '0) begin failures++; $display("FAIL rst_mid_ram got=%b/%h exp=0/000", ram_we, ram_addr); end
    checks++; if (b_busy !== 1'b1 || b_dout !== '0) begin failures++; $display("FAIL rst_mid_b got=%b/%h exp=1/00", b_busy, b_dout); end
    nxt();
    rst_n = 1;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      eb = (c < 3);
      checks++; if (b_busy !== eb) begin failures++; $display("FAIL rst_after c=%0d got=%b exp=%b", c, b_busy, eb); end
      if (c == 3) begin checks++; if (b_dout !== 8'h3C) begin failures++; $display("FAIL rst_dout got=%h exp=3c", b_dout); end end
      nxt();
    end
    b_cs = 0;
    nxt();
  endtask

  // each side owns its own address parity, so the shadow memory is exact
  task automatic side_proc(input int s);
    logic [AW-1:0] addr, paddr;
    logic          we, pwe, held;
    logic [DW-1:0] din;
    int            n;
    held = 0; pwe = 0; paddr = '0;
    for (int k = 0; k < 40; k++) begin
      addr = 11'h400 + AW'($urandom_range(0, 15) * 2 + s);
      we   = 1'($urandom_range(0, 1));
      din  = DW'($urandom);
      if (held && (({addr, we} == {paddr, pwe}) || $urandom_range(0, 2) == 0)) begin
        set_cs(s, 0);
        repeat ($urandom_range(1, 2)) nxt();
      end
      drive(s, 1, we, addr, din);
      n = 0;
      while (1) begin
        @(negedge clk);
        if (!get_busy(s) || n >= 20) break;
        n++;
        nxt();
      end
      checks++; if (n < 3 || n > 6) begin failures++; $display("FAIL rnd_wait side=%0d got=%0d exp=3..6", s, n); end
      if (!we) begin
        checks++; if (get_dout(s) !== exp_mem[addr]) begin failures++; $display("FAIL rnd_rd side=%0d addr=%h got=%h exp=%h", s, addr, get_dout(s), exp_mem[addr]); end
      end else exp_mem[addr] = din;
      held = 1; paddr = addr; pwe = we;
      nxt();
    end
    set_cs(s, 0);
  endtask

  task automatic test_random;
    do_reset();
    for (int i = 0; i < 32; i++) preload(11'h400 + AW'(i), DW'($urandom));
    fork
      side_proc(0);
      side_proc(1);
    join
    idle_inputs();
    nxt();
  endtask

  initial begin
    pre_en = 0; pre_addr = '0; pre_data = '0;
    test_reset();
    test_read_uncontested();
    test_contested();
    test_round_robin();
    test_addr_change();
    test_cs_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
